biriscv_irq_ctrl: RTL
=====================

// Module: biriscv_irq_ctrl
// PURPOSE
//  Interrupt controller feeding the CSR unit's external interrupt input (intr_i).
//  - Synchronises NUM_SRC asynchronous sources; each source is edge- or level-triggered.
//  - Latches pending state per source.
//  - Drives a single level intr_o to the core.
//  - Software claims and completes interrupts through a small register port.
// PARAMETERS
//  NUM_SRC      16  number of interrupt sources, 1..31; source k reports claim id k+1
//  SYNC_STAGES   2  synchroniser flops per source, >=2
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        reset, asynchronous, active-high
//  irq_src_i    in   NUM_SRC  raw async interrupt lines, active-high
//  cfg_req_i    in   1        register access request, one-cycle strobe
//  cfg_wr_i     in   1        1=write, 0=read
//  cfg_addr_i   in   8        byte address; bits [1:0] ignored
//  cfg_wdata_i  in   32       write data
//  cfg_ack_o    out  1        access done, pulses one cycle after cfg_req_i
//  cfg_rdata_o  out  32       read data, valid while cfg_ack_o=1, else 0
//  intr_o       out  1        to CSR unit intr_i; registered
// BEHAVIOUR
//  Clock and reset
//   - One clock, clk_i. Reset rst_i is asynchronous and active-high.
//   - Reset: all sync flops, pending, enable, edge_mode and in_service = 0.
//   - Reset: cfg_ack_o=0, cfg_rdata_o=0, intr_o=0.
//   - Reset mid-access drops the access; no ack is issued.
//  Registers
//   - 0x00 PENDING  RO; writes ignored.
//   - 0x04 ENABLE   RW; bits >= NUM_SRC read 0.
//   - 0x08 EDGE     RW; 1=rising-edge source, 0=level source.
//   - 0x0C CLAIM    read = claim; write = complete.
//   - 0x10 INSERV   RO; in_service vector.
//   - Unmapped address: read 0, write ignored; still acked.
//  Access handshake
//   - cfg_req_i sampled at clock edge N.
//   - All side effects commit at edge N.
//   - cfg_ack_o=1 and cfg_rdata_o are driven for the cycle after edge N.
//   - A new request may arrive every cycle and each gets its own ack.
//  Synchroniser
//   - s = last synchroniser stage; p = s delayed one cycle.
//   - Edge detect: rise = s & ~p.
//  Pending set, per source k
//   - Edge mode: pend_k set on rise_k, including while k is in service (edges are never lost).
//   - Level mode: pend_k = s_k & ~inserv_k, re-evaluated every cycle.
//   - ENABLE does not gate pending capture.
//  Claim (read of 0x0C)
//   - cand = pend & ENABLE & ~inserv.
//   - id = lowest set index of cand, plus 1; returns 0 if cand is empty.
//   - If id != 0: at the same edge, clear pend[id-1] and set inserv[id-1].
//   - Edge-mode rise on the same source in the claim cycle: the set wins; pend stays 1.
//  Complete (write of id to 0x0C)
//   - Clears inserv[id-1].
//   - Ignored if id==0, id>NUM_SRC, or that source is not in service.
//   - Level source still high after complete: pend=1 on the next edge.
//  Interrupt output
//   - intr_o <= |(pend & ENABLE & ~inserv), registered.
//   - Latency, edge source: sync + 2 edges after the first sampling edge where irq_src_i=1.
//     SYNC_STAGES=2 gives intr_o high at edge 4.
//   - intr_o falls one edge after the claim commits, unless another candidate remains.
//  Config writes
//   - Writing EDGE or ENABLE does not modify pend or inserv.
//   - A mode change takes effect on the next cycle's evaluation.
// STRUCTURE
//  - biriscv_defs.v gains `IRQ_PENDING/`IRQ_ENABLE/`IRQ_EDGE/`IRQ_CLAIM/`IRQ_INSERV offsets
//    and `IRQ_ID_W (5).
//  - Sub-module biriscv_irq_sync: per-source SYNC_STAGES synchroniser, delayed copy, rise output.
//    Instantiated NUM_SRC times via generate.
//  - Top: register file, claim priority encoder (lowest index), ack/rdata pipeline, intr_o flop.
// TESTING
//  1. Reset, then read all regs.
//     -> every read = 0, intr_o=0, each ack exactly one cycle after req.
//  2. ENABLE=0x0004, EDGE=0x0004, pulse irq_src_i[2] for 1 cycle.
//     -> intr_o=1 at edge 4.
//     -> CLAIM read = 3, then intr_o=0.
//     -> INSERV=0x0004; write CLAIM=3 -> INSERV=0.
//  3. Level source 5 held high, ENABLE bit5.
//     -> claim returns 6; intr_o stays 0 while in service.
//     -> after complete 6, PENDING bit5=1 and intr_o=1 again.
//  4. Sources 1 and 7 pending and enabled.
//     -> claims return 2, then 8, then 0 (no state change on the third).
//  5. Edge source 0 in service, second edge arrives, and a rise coincides with a claim.
//     -> PENDING bit0 stays 1; intr_o rises only after complete 1.
//  6. Complete with id 0, 17, and a not-in-service id; unmapped read; reset asserted mid-access.
//     -> no state change, unmapped read = 0, no ack after reset.

Source files
------------

// File: rtl/biriscv_irq_ctrl_pkg.sv
// Shared definitions for the biriscv interrupt controller: register map,
// claim id width and the lowest-index claim priority encoder.
package biriscv_irq_ctrl_pkg;

    localparam int unsigned IRQ_ID_W   = 5;
    localparam int unsigned CFG_DATA_W = 32;
    localparam int unsigned CFG_ADDR_W = 8;

    // Word offsets (byte address bits [7:2]) of the register port
    typedef enum logic [5:0] {
        IRQ_PENDING = 6'h00,
        IRQ_ENABLE  = 6'h01,
        IRQ_EDGE    = 6'h02,
        IRQ_CLAIM   = 6'h03,
        IRQ_INSERV  = 6'h04
    } irq_reg_e;

    // Lowest set index plus one; zero when no candidate is present
    function automatic logic [IRQ_ID_W-1:0] irq_lowest_id(input logic [30:0] cand);
        logic [IRQ_ID_W-1:0] id;
        id = '0;
        for (int i = 30; i >= 0; i--) begin
            if (cand[i]) begin
                id = IRQ_ID_W'(i + 1);
            end
        end
        return id;
    endfunction

endpackage

// File: rtl/biriscv_irq_sync.sv
// Per-source synchroniser: SYNC_STAGES flops, a delayed copy of the last
// stage, and the rising-edge strobe derived from the two.
module biriscv_irq_sync
    import biriscv_irq_ctrl_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_irq,
    output logic o_sync,
    output logic o_rise_c
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync   = r_sync[SYNC_STAGES-1];
    assign o_rise_c = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/biriscv_irq_ctrl.sv
// Interrupt controller for the CSR unit's external interrupt input: pending
// capture, claim/complete register port and the registered intr_o level.
module biriscv_irq_ctrl
    import biriscv_irq_ctrl_pkg::*;
#(
    parameter int unsigned NUM_SRC     = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_SRC-1:0]    irq_src_i,
    input  logic                  cfg_req_i,
    input  logic                  cfg_wr_i,
    input  logic [CFG_ADDR_W-1:0] cfg_addr_i,
    input  logic [CFG_DATA_W-1:0] cfg_wdata_i,
    output logic                  cfg_ack_o,
    output logic [CFG_DATA_W-1:0] cfg_rdata_o,
    output logic                  intr_o
);

    logic [NUM_SRC-1:0]    w_sync;
    logic [NUM_SRC-1:0]    w_rise;
    logic [NUM_SRC-1:0]    r_pend;
    logic [NUM_SRC-1:0]    r_enable;
    logic [NUM_SRC-1:0]    r_edge;
    logic [NUM_SRC-1:0]    r_inserv;
    logic [NUM_SRC-1:0]    w_cand;
    logic [NUM_SRC-1:0]    w_claim_set;
    logic [NUM_SRC-1:0]    w_cmpl_clr;
    logic [NUM_SRC-1:0]    w_pend_nxt;
    logic [NUM_SRC-1:0]    w_inserv_nxt;
    logic [IRQ_ID_W-1:0]   w_claim_id;
    logic [5:0]            w_reg;
    logic                  w_rd;
    logic                  w_wr;
    logic                  w_claim_rd;
    logic                  w_cmpl_wr;
    logic [CFG_DATA_W-1:0] w_rdata;
    logic                  w_unused;

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_sync
        biriscv_irq_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk    (clk_i),
            .i_rst    (rst_i),
            .i_irq    (irq_src_i[k]),
            .o_sync   (w_sync[k]),
            .o_rise_c (w_rise[k])
        );
    end

    assign w_unused   = ^cfg_addr_i[1:0];
    assign w_reg      = cfg_addr_i[7:2];
    assign w_rd       = cfg_req_i & ~cfg_wr_i;
    assign w_wr       = cfg_req_i & cfg_wr_i;
    assign w_cand     = r_pend & r_enable & ~r_inserv;
    assign w_claim_id = irq_lowest_id(31'(w_cand));
    assign w_claim_rd = w_rd && (w_reg == IRQ_CLAIM);
    assign w_cmpl_wr  = w_wr && (w_reg == IRQ_CLAIM);

    // Pending / in-service update; an edge-mode rise beats a same-cycle claim
    always_comb begin
        w_claim_set  = '0;
        w_cmpl_clr   = '0;
        w_pend_nxt   = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_claim_set[k] = w_claim_rd && (w_claim_id == IRQ_ID_W'(k + 1));
            w_cmpl_clr[k]  = w_cmpl_wr && (cfg_wdata_i == CFG_DATA_W'(k + 1)) && r_inserv[k];
            if (r_edge[k]) begin
                w_pend_nxt[k] = (r_pend[k] & ~w_claim_set[k]) | w_rise[k];
            end else begin
                w_pend_nxt[k] = w_sync[k] & ~r_inserv[k] & ~w_claim_set[k];
            end
        end
        w_inserv_nxt = (r_inserv | w_claim_set) & ~w_cmpl_clr;
    end

    always_comb begin
        w_rdata = '0;
        case (w_reg)
            IRQ_PENDING: w_rdata = CFG_DATA_W'(r_pend);
            IRQ_ENABLE:  w_rdata = CFG_DATA_W'(r_enable);
            IRQ_EDGE:    w_rdata = CFG_DATA_W'(r_edge);
            IRQ_CLAIM:   w_rdata = CFG_DATA_W'(w_claim_id);
            IRQ_INSERV:  w_rdata = CFG_DATA_W'(r_inserv);
            default:     w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_pend      <= '0;
            r_enable    <= '0;
            r_edge      <= '0;
            r_inserv    <= '0;
            cfg_ack_o   <= 1'b0;
            cfg_rdata_o <= '0;
            intr_o      <= 1'b0;
        end else begin
            r_pend   <= w_pend_nxt;
            r_inserv <= w_inserv_nxt;
            if (w_wr && (w_reg == IRQ_ENABLE)) begin
                r_enable <= cfg_wdata_i[NUM_SRC-1:0];
            end
            if (w_wr && (w_reg == IRQ_EDGE)) begin
                r_edge <= cfg_wdata_i[NUM_SRC-1:0];
            end
            cfg_ack_o   <= cfg_req_i;
            cfg_rdata_o <= w_rd ? w_rdata : '0;
            intr_o      <= |w_cand;
        end
    end

endmodule
